// File: rtl/jtag_tap_multi.sv
// jtag_tap_multi: IEEE 1149.1 TAP controller.
// It provides the IDCODE and BYPASS registers plus NUM_USER_DR user data registers.
// Optional feature: define JTAG_TAP_MULTI_OPCODE_ERR_EN to add a sticky flag.
// The flag records that an unknown opcode was loaded into the instruction register.
// When the flag is present, Capture-IR reports it in IR bit 2.
module jtag_tap_multi #(
    parameter int          IR_WIDTH      = 5,
    parameter int          NUM_USER_DR   = 2,
    parameter int          USER_DR_WIDTH = 8,
    parameter logic [31:0] IDCODE_VALUE  = 32'hC0AFE01B
) (
    input  logic                                   tck,
    input  logic                                   trst,
    input  logic                                   tms,
    input  logic                                   tdi,
    output logic                                   tdo,
    output logic                                   tdo_en,
    output logic [3:0]                             tap_state,
    output logic [IR_WIDTH-1:0]                    instruction,
    input  logic [NUM_USER_DR*USER_DR_WIDTH-1:0]   user_dr_d,
    output logic [NUM_USER_DR*USER_DR_WIDTH-1:0]   user_dr_q,
    output logic [NUM_USER_DR-1:0]                 update_strobe
);

    localparam int UW = NUM_USER_DR * USER_DR_WIDTH;
    localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] OP_BYPASS = '1;

    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC,
        SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
        PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
        SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
        PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } tap_state_e;

    tap_state_e           state_q;
    logic [IR_WIDTH-1:0]  ir_sr_q;
    logic [IR_WIDTH-1:0]  instr_q;
    logic [IR_WIDTH-1:0]  ir_capture;
    logic                 bypass_sr_q;
    logic [31:0]          idcode_sr_q;
    logic [UW-1:0]        usr_sr_q;
    logic [UW-1:0]        usr_upd_q;
    logic [NUM_USER_DR-1:0] strobe_q;
    logic [NUM_USER_DR-1:0] usr_sel;
    logic [NUM_USER_DR-1:0] usr_lsb;
    logic                 sel_idcode;
    logic                 sel_bypass;

    // Standard 1149.1 transition graph; tms chooses the branch out of each state.
    function automatic tap_state_e tap_next(input tap_state_e s, input logic m);
        case (s)
            TLR:     return m ? TLR    : RTI;
            RTI:     return m ? SEL_DR : RTI;
            SEL_DR:  return m ? SEL_IR : CAP_DR;
            CAP_DR:  return m ? EX1_DR : SH_DR;
            SH_DR:   return m ? EX1_DR : SH_DR;
            EX1_DR:  return m ? UPD_DR : PAU_DR;
            PAU_DR:  return m ? EX2_DR : PAU_DR;
            EX2_DR:  return m ? UPD_DR : SH_DR;
            UPD_DR:  return m ? SEL_DR : RTI;
            SEL_IR:  return m ? TLR    : CAP_IR;
            CAP_IR:  return m ? EX1_IR : SH_IR;
            SH_IR:   return m ? EX1_IR : SH_IR;
            EX1_IR:  return m ? UPD_IR : PAU_IR;
            PAU_IR:  return m ? EX2_IR : PAU_IR;
            EX2_IR:  return m ? UPD_IR : SH_IR;
            UPD_IR:  return m ? SEL_DR : RTI;
            default: return TLR;
        endcase
    endfunction

    // Shift toward the LSB, with the new bit entering at the MSB.
    // Written as a shift plus a bit set so that it also works for 1-bit registers.
    function automatic logic [USER_DR_WIDTH-1:0] shift_usr(input logic [USER_DR_WIDTH-1:0] v,
                                                          input logic b);
        logic [USER_DR_WIDTH-1:0] r;
        r = v >> 1;
        r[USER_DR_WIDTH-1] = b;
        return r;
    endfunction

    function automatic logic [IR_WIDTH-1:0] shift_ir(input logic [IR_WIDTH-1:0] v, input logic b);
        logic [IR_WIDTH-1:0] r;
        r = v >> 1;
        r[IR_WIDTH-1] = b;
        return r;
    endfunction

    // USERk opcodes are 2+k.
    // An opcode that is also the all-ones BYPASS code stays BYPASS.
    // An opcode too large for the IR can never select a user register.
    for (genvar gi = 0; gi < NUM_USER_DR; gi++) begin : g_usr
        if (gi + 2 < (1 << IR_WIDTH)) begin : g_reach
            assign usr_sel[gi] = (instr_q == IR_WIDTH'(gi + 2)) && (instr_q != OP_BYPASS);
        end else begin : g_unreach
            assign usr_sel[gi] = 1'b0;
        end
        assign usr_lsb[gi] = usr_sr_q[gi*USER_DR_WIDTH];
    end

    assign sel_idcode = (instr_q == OP_IDCODE);
    assign sel_bypass = !sel_idcode && !(|usr_sel);

`ifdef JTAG_TAP_MULTI_OPCODE_ERR_EN
    logic opcode_err_q;

    // Returns true for an opcode that decodes to BYPASS only by falling through.
    // The all-ones code is the real BYPASS opcode and is not flagged.
    function automatic logic is_unknown_op(input logic [IR_WIDTH-1:0] op);
        logic known;
        known = (op == OP_IDCODE) || (op == OP_BYPASS);
        for (int k = 0; k < NUM_USER_DR; k++) begin
            if ((k + 2) < (1 << IR_WIDTH) && op == IR_WIDTH'(k + 2)) known = 1'b1;
        end
        return !known;
    endfunction

    // Capture-IR value: the flag sits in bit 2. It is truncated away when IR_WIDTH is 2.
    assign ir_capture = IR_WIDTH'({opcode_err_q, 2'b01});
`else
    assign ir_capture = IR_WIDTH'(2'b01);
`endif

    // TAP state register; trst takes priority over tms in every state.
    always_ff @(posedge tck) begin
        if (trst) state_q <= TLR;
        else      state_q <= tap_next(state_q, tms);
    end

    // Instruction and data registers, acting on the state being left at this edge.
    always_ff @(posedge tck) begin
        if (trst) begin
            ir_sr_q     <= '0;
            instr_q     <= OP_IDCODE;
            bypass_sr_q <= 1'b0;
            idcode_sr_q <= '0;
            usr_sr_q    <= '0;
            usr_upd_q   <= '0;
            strobe_q    <= '0;
`ifdef JTAG_TAP_MULTI_OPCODE_ERR_EN
            opcode_err_q <= 1'b0;
`endif
        end else begin
            strobe_q <= '0;
            case (state_q)
                CAP_IR: ir_sr_q <= ir_capture;
                SH_IR:  ir_sr_q <= shift_ir(ir_sr_q, tdi);
                UPD_IR: begin
                    instr_q <= ir_sr_q;
`ifdef JTAG_TAP_MULTI_OPCODE_ERR_EN
                    if (is_unknown_op(ir_sr_q)) opcode_err_q <= 1'b1;
`endif
                end
                CAP_DR: begin
                    if (sel_idcode) idcode_sr_q <= IDCODE_VALUE;
                    if (sel_bypass) bypass_sr_q <= 1'b0;
                    for (int k = 0; k < NUM_USER_DR; k++) begin
                        if (usr_sel[k])
                            usr_sr_q[k*USER_DR_WIDTH +: USER_DR_WIDTH] <=
                                user_dr_d[k*USER_DR_WIDTH +: USER_DR_WIDTH];
                    end
                end
                SH_DR: begin
                    if (sel_idcode) idcode_sr_q <= {tdi, idcode_sr_q[31:1]};
                    if (sel_bypass) bypass_sr_q <= tdi;
                    for (int k = 0; k < NUM_USER_DR; k++) begin
                        if (usr_sel[k])
                            usr_sr_q[k*USER_DR_WIDTH +: USER_DR_WIDTH] <=
                                shift_usr(usr_sr_q[k*USER_DR_WIDTH +: USER_DR_WIDTH], tdi);
                    end
                end
                UPD_DR: begin
                    for (int k = 0; k < NUM_USER_DR; k++) begin
                        if (usr_sel[k]) begin
                            usr_upd_q[k*USER_DR_WIDTH +: USER_DR_WIDTH] <=
                                usr_sr_q[k*USER_DR_WIDTH +: USER_DR_WIDTH];
                            strobe_q[k] <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            // Entering or staying in Test-Logic-Reset restores IDCODE.
            // It leaves the user update registers alone.
            if (tap_next(state_q, tms) == TLR) begin
                instr_q <= OP_IDCODE;
`ifdef JTAG_TAP_MULTI_OPCODE_ERR_EN
                opcode_err_q <= 1'b0;
`endif
            end
        end
    end

    // Serial output: the LSB of whichever register is currently shifting.
    always_comb begin
        tdo = 1'b0;
        if (state_q == SH_IR) begin
            tdo = ir_sr_q[0];
        end else if (state_q == SH_DR) begin
            if (sel_idcode)      tdo = idcode_sr_q[0];
            else if (sel_bypass) tdo = bypass_sr_q;
            else                 tdo = |(usr_lsb & usr_sel);
        end
    end

    assign tdo_en        = (state_q == SH_DR) || (state_q == SH_IR);
    assign tap_state     = state_q;
    assign instruction   = instr_q;
    assign user_dr_q     = usr_upd_q;
    assign update_strobe = strobe_q;

endmodule

// File: tb/tb_jtag_tap_multi.sv
// Self-checking bench for jtag_tap_multi.
// It runs a table-driven FSM walk, directed multi-cycle sequences and a randomized run.
// The randomized run is checked against a queue-based reference model.
module tb_jtag_tap_multi;

    localparam int IRW = 5;
    localparam int N   = 2;
    localparam int W   = 8;
    localparam logic [31:0] IDC = 32'hC0AFE01B;

    logic tck = 1'b0;
    logic trst, tms, tdi;
    logic tdo, tdo_en;
    logic [3:0] tap_state;
    logic [IRW-1:0] instruction;
    logic [N*W-1:0] user_dr_d, user_dr_q;
    logic [N-1:0] update_strobe;

    int n_checks = 0;
    int n_fail   = 0;

    jtag_tap_multi #(.IR_WIDTH(IRW), .NUM_USER_DR(N), .USER_DR_WIDTH(W), .IDCODE_VALUE(IDC)) dut (
        .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
        .tap_state(tap_state), .instruction(instruction), .user_dr_d(user_dr_d),
        .user_dr_q(user_dr_q), .update_strobe(update_strobe)
    );

    always #5 tck = ~tck;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic tick(input logic m, input logic d);
        tms = m;
        tdi = d;
        @(posedge tck);
        #1;
    endtask

    task automatic do_reset();
        trst = 1'b1;
        tick(1'b0, 1'b0);
        trst = 1'b0;
    endtask

    // From Run-Test/Idle: load an opcode into the IR and return to Run-Test/Idle.
    task automatic load_ir(input logic [IRW-1:0] op);
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < IRW; i++) tick(i == IRW - 1, op[i]);
        tick(1, 0); tick(0, 0);
    endtask

    task automatic goto_shdr();
        tick(1, 0); tick(0, 0); tick(0, 0);
    endtask

    // Shift n bits from the Shift-DR state and collect tdo.
    // The last bit leaves with tms=1 when last_exit is set.
    task automatic shift_dr(input logic [63:0] din, input int n, input logic last_exit,
                            output logic [63:0] dout);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo;
            tick(last_exit && (i == n - 1), din[i]);
        end
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic       rst;
        logic       m;
        logic       d;
        logic [3:0] st;
        logic       en;
        logic       o;
    } vec_t;
    vec_t walk[$];

    task automatic add(input logic r, input logic m, input logic d, input logic [3:0] st,
                       input logic en, input logic o);
        vec_t v;
        v.rst = r; v.m = m; v.d = d; v.st = st; v.en = en; v.o = o;
        walk.push_back(v);
    endtask

    // ---------------- reference model ----------------
    logic [3:0] nxt0 [16];
    logic [3:0] nxt1 [16];
    logic [3:0] m_st;
    logic [IRW-1:0] m_instr;
    bit m_irq[$];
    bit m_drq[$];
    logic [N*W-1:0] m_user;
    logic [N-1:0] m_strobe;
    bit m_flag;

    // Opcode decode: -1 means IDCODE, -2 means BYPASS, k >= 0 means USERk.
    function automatic int sel_of(input logic [IRW-1:0] op);
        int v;
        v = int'(op);
        if (v == 1) return -1;
        if (v == (1 << IRW) - 1) return -2;
        if (v >= 2 && v < 2 + N) return v - 2;
        return -2;
    endfunction

    function automatic logic [63:0] pack_q(input bit q[$]);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < q.size(); i++) r[i] = q[i];
        return r;
    endfunction

    task automatic model_step(input logic r, input logic m, input logic d, input logic [N*W-1:0] ud);
        int s;
        logic [63:0] capv;
        if (r) begin
            m_st = 4'hF; m_instr = IRW'(1); m_user = '0; m_strobe = '0; m_flag = 0;
            m_irq.delete(); m_drq.delete();
            for (int i = 0; i < IRW; i++) m_irq.push_back(1'b0);
            return;
        end
        m_strobe = '0;
        s = sel_of(m_instr);
        case (m_st)
            4'h6: begin
                m_drq.delete();
                if (s == -1) for (int i = 0; i < 32; i++) m_drq.push_back(IDC[i]);
                else if (s == -2) m_drq.push_back(1'b0);
                else for (int i = 0; i < W; i++) m_drq.push_back(ud[s*W + i]);
            end
            4'h2: begin void'(m_drq.pop_front()); m_drq.push_back(d); end
            4'h5: if (s >= 0) begin
                capv = pack_q(m_drq);
                m_user[s*W +: W] = capv[W-1:0];
                m_strobe[s] = 1'b1;
            end
            4'hE: begin
`ifdef JTAG_TAP_MULTI_OPCODE_ERR_EN
                capv = 64'd1 + (m_flag ? 64'd4 : 64'd0);
`else
                capv = 64'd1;
`endif
                m_irq.delete();
                for (int i = 0; i < IRW; i++) m_irq.push_back(capv[i]);
            end
            4'hA: begin void'(m_irq.pop_front()); m_irq.push_back(d); end
            4'hD: begin
                capv = pack_q(m_irq);
                m_instr = capv[IRW-1:0];
`ifdef JTAG_TAP_MULTI_OPCODE_ERR_EN
                if (sel_of(m_instr) == -2 && int'(m_instr) != (1 << IRW) - 1) m_flag = 1;
`endif
            end
            default: ;
        endcase
        m_st = m ? nxt1[m_st] : nxt0[m_st];
        if (m_st == 4'hF) begin m_instr = IRW'(1); m_flag = 0; end
    endtask

    initial begin
        logic [63:0] dout, dlo, dhi;
        logic        exp_en, exp_o, r, m, d;

        trst = 1'b1; tms = 1'b0; tdi = 1'b0; user_dr_d = '0;
        nxt0 = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                 4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
        nxt1 = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                 4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

        // Reset state
        do_reset();
        check("rst_state", tap_state, 4'hF);
        check("rst_instr", instruction, 1);
        check("rst_user", user_dr_q, 0);
        check("rst_strobe", update_strobe, 0);
        check("rst_tdo_en", tdo_en, 0);
        check("rst_tdo", tdo, 0);

        // Table-driven walk through all 16 states
        add(1, 0, 0, 4'hF, 0, 0); add(0, 0, 0, 4'hC, 0, 0); add(0, 1, 0, 4'h7, 0, 0);
        add(0, 0, 0, 4'h6, 0, 0); add(0, 0, 0, 4'h2, 1, 1); add(0, 1, 0, 4'h1, 0, 0);
        add(0, 0, 0, 4'h3, 0, 0); add(0, 1, 0, 4'h0, 0, 0); add(0, 0, 0, 4'h2, 1, 1);
        add(0, 1, 0, 4'h1, 0, 0); add(0, 1, 0, 4'h5, 0, 0); add(0, 1, 0, 4'h7, 0, 0);
        add(0, 1, 0, 4'h4, 0, 0); add(0, 0, 0, 4'hE, 0, 0); add(0, 0, 0, 4'hA, 1, 1);
        add(0, 1, 0, 4'h9, 0, 0); add(0, 0, 0, 4'hB, 0, 0); add(0, 1, 0, 4'h8, 0, 0);
        add(0, 0, 0, 4'hA, 1, 0); add(0, 1, 0, 4'h9, 0, 0); add(0, 1, 0, 4'hD, 0, 0);
        add(0, 0, 0, 4'hC, 0, 0); add(0, 1, 0, 4'h7, 0, 0); add(0, 1, 0, 4'h4, 0, 0);
        add(0, 1, 0, 4'hF, 0, 0);
        for (int i = 0; i < walk.size(); i++) begin
            trst = walk[i].rst;
            tick(walk[i].m, walk[i].d);
            trst = 1'b0;
            check($sformatf("walk%0d_state", i), tap_state, walk[i].st);
            check($sformatf("walk%0d_tdo_en", i), tdo_en, walk[i].en);
            check($sformatf("walk%0d_tdo", i), tdo, walk[i].o);
        end
        check("walk_tlr_instr", instruction, 1);

        // IDCODE read out after reset
        do_reset();
        tick(0, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        check("id_in_shdr", tap_state, 4'h2);
        shift_dr(64'd0, 32, 1, dout);
        check("idcode_serial", dout[31:0], IDC);
        check("idcode_instr", instruction, 1);
        tick(1, 0); tick(0, 0);
        check("id_upd_user", user_dr_q, 0);
        check("id_upd_strobe", update_strobe, 0);

        // Five tms=1 edges from Shift-IR reach TLR
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        check("in_shir", tap_state, 4'hA);
        for (int i = 0; i < 5; i++) tick(1, 0);
        check("tms5_state", tap_state, 4'hF);
        check("tms5_instr", instruction, 1);
        tick(0, 0);

        // BYPASS gives a one-bit delay
        load_ir('1);
        check("byp_instr", instruction, 5'h1F);
        goto_shdr();
        shift_dr(64'b1101, 4, 1, dout);
        check("byp_tdo", dout[3:0], 4'b1010);
        tick(1, 0); tick(0, 0);
        check("byp_upd_user", user_dr_q, 0);
        check("byp_upd_strobe", update_strobe, 0);

        // USER1: capture 3C, shift in 96
        user_dr_d = 16'h3C77;
        load_ir(3);
        goto_shdr();
        shift_dr(64'h96, 8, 1, dout);
        check("u1_capture", dout[7:0], 8'h3C);
        tick(1, 0);
        check("u1_strobe_early", update_strobe, 0);
        tick(0, 0);
        check("u1_user", user_dr_q, 16'h9600);
        check("u1_strobe", update_strobe, 2'b10);
        tick(0, 0);
        check("u1_strobe_off", update_strobe, 0);

        // USER0: shift in A5, USER1 value kept
        load_ir(2);
        goto_shdr();
        shift_dr(64'hA5, 8, 1, dout);
        check("u0_capture", dout[7:0], 8'h77);
        tick(1, 0); tick(0, 0);
        check("u0_user", user_dr_q, 16'h96A5);
        check("u0_strobe", update_strobe, 2'b01);
        tick(0, 0);
        check("u0_strobe_off", update_strobe, 0);

        // trst in the middle of Shift-DR
        goto_shdr();
        shift_dr(64'hFF, 4, 0, dout);
        check("mid_in_shdr", tap_state, 4'h2);
        do_reset();
        check("mid_rst_state", tap_state, 4'hF);
        check("mid_rst_user", user_dr_q, 0);
        check("mid_rst_strobe", update_strobe, 0);
        check("mid_rst_instr", instruction, 1);
        tick(0, 0);
        check("mid_after_strobe", update_strobe, 0);
        check("mid_after_user", user_dr_q, 0);

        // Pause and resume, then leave through TLR with tms only
        user_dr_d = 16'h005E;
        load_ir(2);
        goto_shdr();
        shift_dr(64'h3, 4, 1, dlo);
        tick(0, 0); tick(0, 0);
        check("pause_state", tap_state, 4'h3);
        tick(1, 0); tick(0, 0);
        check("resume_state", tap_state, 4'h2);
        shift_dr(64'hC, 4, 1, dhi);
        check("pause_capture", {dhi[3:0], dlo[3:0]}, 8'h5E);
        tick(0, 0);
        for (int i = 0; i < 5; i++) tick(1, 0);
        check("pau_tlr_state", tap_state, 4'hF);
        check("pau_tlr_user", user_dr_q, 16'h00C3);
        check("pau_tlr_strobe", update_strobe, 0);
        check("pau_tlr_instr", instruction, 1);
        tick(0, 0);

        // Unknown opcode 01010: Capture-IR reports the flag when the feature is built in
        load_ir(5'b01010);
        check("unk_instr", instruction, 5'b01010);
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        dout = '0;
        for (int i = 0; i < IRW; i++) begin
            dout[i] = tdo;
            tick(i == IRW - 1, IRW'(5'b01010) >> i);
        end
`ifdef JTAG_TAP_MULTI_OPCODE_ERR_EN
        check("unk_ircap", dout[4:0], 5'b00101);
`else
        check("unk_ircap", dout[4:0], 5'b00001);
`endif
        tick(1, 0); tick(0, 0);
        check("unk_instr2", instruction, 5'b01010);
        goto_shdr();
        shift_dr(64'b11, 2, 1, dout);
        check("unk_bypass", dout[1:0], 2'b10);
        tick(1, 0); tick(0, 0);
        for (int i = 0; i < 5; i++) tick(1, 0);
        tick(0, 0);
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        dout = '0;
        for (int i = 0; i < IRW; i++) begin
            dout[i] = tdo;
            tick(i == IRW - 1, 1'b0);
        end
        check("tlr_clears_flag", dout[4:0], 5'b00001);
        tick(1, 0); tick(0, 0);

        // Randomized run against the reference model
        do_reset();
        model_step(1, 0, 0, user_dr_d);
        for (int it = 0; it < 3000; it++) begin
            r = ($urandom_range(0, 199) == 0);
            m = ($urandom_range(0, 99) < 30);
            d = 1'($urandom);
            if ($urandom_range(0, 15) == 0) user_dr_d = (N*W)'($urandom);
            trst = r;
            tick(m, d);
            trst = 1'b0;
            model_step(r, m, d, user_dr_d);
            exp_en = (m_st == 4'h2) || (m_st == 4'hA);
            exp_o  = 1'b0;
            if (m_st == 4'hA && m_irq.size() > 0) exp_o = m_irq[0];
            if (m_st == 4'h2 && m_drq.size() > 0) exp_o = m_drq[0];
            check("rnd_state", tap_state, m_st);
            check("rnd_tdo_en", tdo_en, exp_en);
            check("rnd_tdo", tdo, exp_o);
            check("rnd_instr", instruction, m_instr);
            check("rnd_user", user_dr_q, m_user);
            check("rnd_strobe", update_strobe, m_strobe);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_tap_multi.md
JTAG_TAP_MULTI -- requirements
Module: jtag_tap_multi

Interface
REQ-001 The block SHALL have parameter IR_WIDTH, default 5, giving the instruction register width (minimum 2).
REQ-002 The block SHALL have parameter NUM_USER_DR, default 2, giving the user data register count (1..8).
REQ-003 The block SHALL have parameter USER_DR_WIDTH, default 8, giving the bits per user data register (minimum 1).
REQ-004 The block SHALL have parameter IDCODE_VALUE, default 32'hC0AFE01B (version C, part AFE, manufacturer 00D, bit0 = 1), giving the 32-bit device ID.
REQ-005 The block SHALL have port tck, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-006 The block SHALL have port trst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port tms, input, 1 bit: test mode select.
REQ-008 The block SHALL have port tdi, input, 1 bit: serial data in.
REQ-009 The block SHALL have port tdo, output, 1 bit: serial data out.
REQ-010 The block SHALL have port tdo_en, output, 1 bit: high only in Shift-DR and Shift-IR.
REQ-011 The block SHALL have port tap_state, output, 4 bits: current state encoding.
REQ-012 The block SHALL have port instruction, output, IR_WIDTH bits: the active (updated) instruction.
REQ-013 The block SHALL have port user_dr_d, input, NUM_USER_DR*USER_DR_WIDTH bits: capture values, channel k at slice k.
REQ-014 The block SHALL have port user_dr_q, output, NUM_USER_DR*USER_DR_WIDTH bits: updated values per channel.
REQ-015 The block SHALL have port update_strobe, output, NUM_USER_DR bits: one-cycle pulse per channel on update.

Function
REQ-016 The block SHALL implement the 16-state IEEE 1149.1 TAP FSM driven by tms, with the tap_state encoding TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D.
REQ-017 The block SHALL reach TLR after five consecutive tms=1 edges, from any state.
REQ-018 The block SHALL decode opcodes as: 1 = IDCODE; all-ones = BYPASS; 2+k (k < NUM_USER_DR) = USERk; any other opcode = BYPASS.
REQ-019 Capture-IR SHALL load the IR shift register with {zeros, 2'b01}.
REQ-020 Capture-DR SHALL load the selected register: IDCODE_VALUE for IDCODE; 0 for BYPASS; the user_dr_d slice for USERk.
REQ-021 In each Shift state, on each edge, the selected shift register SHALL shift toward its LSB with tdi entering the MSB.
REQ-022 tdo SHALL be combinationally equal to the selected register's LSB while tdo_en=1, and 0 otherwise.
REQ-023 Each TLR entry SHALL load instruction with IDCODE (1).
REQ-024 Update-IR SHALL copy the IR shift register to instruction on the edge that leaves Update-IR.
REQ-025 Update-DR with USERk active SHALL load the user_dr_q slice k and pulse update_strobe[k] for exactly that one cycle.
REQ-026 With BYPASS or IDCODE active, Update-DR SHALL leave user_dr_q unchanged, with no strobe.
REQ-027 Pause states SHALL hold shift contents, and returning to Shift SHALL resume without loss.

Reset
REQ-028 When trst=1 at an edge, the block SHALL go to tap_state=F, instruction=1, all shift registers=0, user_dr_q=0, update_strobe=0.
REQ-029 trst SHALL override tms in any state, including mid-Shift, and any partial shift SHALL be discarded.
REQ-030 A tms-driven TLR entry SHALL NOT clear user_dr_q.

Configuration
REQ-031 With JTAG_TAP_MULTI_OPCODE_ERR_EN defined, the block SHALL set a sticky flag when Update-IR loads an opcode that falls through to BYPASS other than all-ones.
REQ-032 With JTAG_TAP_MULTI_OPCODE_ERR_EN defined, Capture-IR SHALL load {zeros, flag, 2'b01}.
REQ-033 With JTAG_TAP_MULTI_OPCODE_ERR_EN defined, the flag SHALL clear on trst or TLR.
REQ-034 With JTAG_TAP_MULTI_OPCODE_ERR_EN undefined, the flag SHALL be absent and Capture-IR SHALL follow REQ-019.

Verification
REQ-035 trst=1 for 1 cycle, then tms 0,1,0,0, then 32 Shift-DR edges -> tdo serial LSB-first = 32'hC0AFE01B; instruction = 1.
REQ-036 Load IR 5'b11111, Shift-DR tdi pattern 1,0,1,1 -> tdo = 0,1,0,1 (one-bit delay).
REQ-037 Load IR 2, shift 8'hA5 LSB-first, then Update-DR -> user_dr_q[7:0]=A5, update_strobe=2'b01 for one cycle, user_dr_q[15:8] unchanged.
REQ-038 Load IR 3, user_dr_d[15:8]=8'h3C, Capture-DR then 8 shifts -> tdo sequence = 0,0,1,1,1,1,0,0.
REQ-039 trst=1 mid Shift-DR (after 4 of 8 bits) -> tap_state=F, user_dr_q=0, no strobe; separately, tms=1 ×5 from PauDR -> tap_state=F, user_dr_q retained.
REQ-040 JTAG_TAP_MULTI_OPCODE_ERR_EN defined, load IR 5'b01010, then Capture-IR and 5 shifts -> tdo = 1,0,1,0,0; BYPASS is active.
